// File: rtl/pipe_stage_reg.sv
// Inter-stage PC/IR pipeline register with valid/ready handshake, optional
// two-entry skid buffer, synchronous flush and a saturating stall counter.
module pipe_stage_reg #(
  parameter int                  PC_WIDTH  = 32,
  parameter int                  IR_WIDTH  = 32,
  parameter logic [IR_WIDTH-1:0] NOP       = '0,
  parameter bit                  SKID      = 1'b1,
  parameter int                  CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [PC_WIDTH-1:0]  in_PC,
  input  logic [IR_WIDTH-1:0]  in_IR,
  input  logic                 flush,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [PC_WIDTH-1:0]  out_PC,
  output logic [IR_WIDTH-1:0]  out_IR,
  output logic [CNT_WIDTH-1:0] stall_count
);

  logic                 m_vld_q, m_vld_d;
  logic [PC_WIDTH-1:0]  m_pc_q,  m_pc_d;
  logic [IR_WIDTH-1:0]  m_ir_q,  m_ir_d;
  logic                 s_vld_q, s_vld_d;
  logic [PC_WIDTH-1:0]  s_pc_q,  s_pc_d;
  logic [IR_WIDTH-1:0]  s_ir_q,  s_ir_d;
  logic [CNT_WIDTH-1:0] cnt_q,   cnt_d;
  logic                 accept;

  // In skid mode in_ready depends only on a flop, cutting the out_ready->in_ready path.
  assign in_ready = SKID ? !s_vld_q : (!m_vld_q || out_ready);
  assign accept   = in_valid && in_ready;

  always_comb begin
    m_vld_d = m_vld_q;
    m_pc_d  = m_pc_q;
    m_ir_d  = m_ir_q;
    s_vld_d = s_vld_q;
    s_pc_d  = s_pc_q;
    s_ir_d  = s_ir_q;
    if (flush) begin
      m_vld_d = 1'b0;
      s_vld_d = 1'b0;
    end else if (SKID) begin
      if (s_vld_q) begin
        // Both full: in_ready is low, so only a drain moves S into M.
        if (out_ready) begin
          m_vld_d = 1'b1;
          m_pc_d  = s_pc_q;
          m_ir_d  = s_ir_q;
          s_vld_d = 1'b0;
        end
      end else if (!m_vld_q || out_ready) begin
        m_vld_d = accept;
        if (accept) begin
          m_pc_d = in_PC;
          m_ir_d = in_IR;
        end
      end else if (accept) begin
        s_vld_d = 1'b1;
        s_pc_d  = in_PC;
        s_ir_d  = in_IR;
      end
    end else begin
      if (accept) begin
        m_vld_d = 1'b1;
        m_pc_d  = in_PC;
        m_ir_d  = in_IR;
      end else if (out_ready) begin
        m_vld_d = 1'b0;
      end
    end
    if (!SKID) s_vld_d = 1'b0;
  end

  always_comb begin
    cnt_d = cnt_q;
    if (m_vld_q && !out_ready && !(&cnt_q)) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      m_vld_q <= 1'b0;
      m_pc_q  <= '0;
      m_ir_q  <= '0;
      s_vld_q <= 1'b0;
      s_pc_q  <= '0;
      s_ir_q  <= '0;
      cnt_q   <= '0;
    end else begin
      m_vld_q <= m_vld_d;
      m_pc_q  <= m_pc_d;
      m_ir_q  <= m_ir_d;
      s_vld_q <= s_vld_d;
      s_pc_q  <= s_pc_d;
      s_ir_q  <= s_ir_d;
      cnt_q   <= cnt_d;
    end
  end

  assign out_valid   = m_vld_q;
  assign out_PC      = m_vld_q ? m_pc_q : '0;
  assign out_IR      = m_vld_q ? m_ir_q : NOP;
  assign stall_count = cnt_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: skid mode, non-skid mode and a narrow
// stall counter instance share one stimulus bus.
module tb_pipe_stage_reg;
  localparam logic [31:0] NOPW = 32'h0000_0013;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic in_valid = 1'b0, flush = 1'b0, out_ready = 1'b0;
  logic [31:0] in_PC = '0, in_IR = '0;

  logic        rdy1, vld1;
  logic [31:0] pc1, ir1;
  logic [15:0] cnt1;
  logic        rdy0, vld0;
  logic [31:0] pc0, ir0;
  logic [15:0] cnt0;
  logic        rdyc, vldc;
  logic [31:0] pcc, irc;
  logic [3:0]  cntc;

  int tests_run = 0;
  int failed = 0;

  always #5 clk = ~clk;

  pipe_stage_reg #(.NOP(NOPW), .SKID(1'b1)) u_dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy1), .in_PC(in_PC), .in_IR(in_IR),
    .flush(flush), .out_valid(vld1), .out_ready(out_ready), .out_PC(pc1), .out_IR(ir1), .stall_count(cnt1));

  pipe_stage_reg #(.NOP(NOPW), .SKID(1'b0)) u_dut0 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy0), .in_PC(in_PC), .in_IR(in_IR),
    .flush(flush), .out_valid(vld0), .out_ready(out_ready), .out_PC(pc0), .out_IR(ir0), .stall_count(cnt0));

  pipe_stage_reg #(.NOP(NOPW), .SKID(1'b1), .CNT_WIDTH(4)) u_cnt (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdyc), .in_PC(in_PC), .in_IR(in_IR),
    .flush(flush), .out_valid(vldc), .out_ready(out_ready), .out_PC(pcc), .out_IR(irc), .stall_count(cntc));

  // Advance past the next rising edge; inputs are driven and outputs checked off-edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    in_valid = 0; flush = 0; out_ready = 0; in_PC = '0; in_IR = '0;
    #1 reset = 1;
    #3 reset = 0;
    tick();
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] ir, input logic ordy);
    in_valid = v; in_PC = pc; in_IR = ir; out_ready = ordy;
  endtask

  task automatic test_reset();
    do_reset();
    drive(1, 32'h40, 32'd77, 1'b0);
    tick();
    drive(0, 0, 0, 1'b0);
    tick();
    #2 reset = 1;
    #1;
    tests_run++; if (vld1 !== 1'b0) begin failed++; $display("FAIL reset_valid got=%0b exp=0", vld1); end
    tests_run++; if (ir1 !== NOPW || pc1 !== 32'd0) begin failed++; $display("FAIL reset_pc_ir got=%0h/%0h exp=0/%0h", pc1, ir1, NOPW); end
    tests_run++; if (rdy1 !== 1'b1 || rdy0 !== 1'b1) begin failed++; $display("FAIL reset_ready got=%0b/%0b exp=1/1", rdy1, rdy0); end
    tests_run++; if (cnt1 !== 16'd0) begin failed++; $display("FAIL reset_cnt got=%0d exp=0", cnt1); end
    @(negedge clk) reset = 0;
    tick(); tick();
    tests_run++; if (vld1 !== 1'b0 || ir1 !== NOPW || rdy1 !== 1'b1 || cnt1 !== 16'd0) begin
      failed++; $display("FAIL idle_after_reset got v=%0b ir=%0h rdy=%0b cnt=%0d", vld1, ir1, rdy1, cnt1); end
  endtask

  task automatic test_stream();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1, 32'(i * 4), 32'(100 + i), 1'b1);
      #1;
      tests_run++; if (rdy1 !== 1'b1) begin failed++; $display("FAIL stream_ready%0d got=%0b exp=1", i, rdy1); end
      tick();
      tests_run++; if (vld1 !== 1'b1 || pc1 !== 32'(i * 4) || ir1 !== 32'(100 + i)) begin
        failed++; $display("FAIL stream_out%0d got v=%0b pc=%0d ir=%0d exp pc=%0d ir=%0d", i, vld1, pc1, ir1, i * 4, 100 + i); end
    end
    drive(0, 0, 0, 1'b1);
    tick();
    tests_run++; if (vld1 !== 1'b0 || ir1 !== NOPW) begin failed++; $display("FAIL stream_drain got v=%0b ir=%0h", vld1, ir1); end
  endtask

  task automatic test_stall_skid();
    do_reset();
    drive(1, 32'd0, 32'd100, 1'b1);
    tick();
    drive(1, 32'd4, 32'd101, 1'b0);
    tick();
    drive(1, 32'd8, 32'd999, 1'b0);
    #1;
    tests_run++; if (rdy1 !== 1'b0 || ir1 !== 32'd100 || cnt1 !== 16'd1) begin
      failed++; $display("FAIL skid_capture got rdy=%0b ir=%0d cnt=%0d exp 0/100/1", rdy1, ir1, cnt1); end
    tick(); tick();
    tests_run++; if (cnt1 !== 16'd3 || ir1 !== 32'd100) begin failed++; $display("FAIL stall_cnt got cnt=%0d ir=%0d exp 3/100", cnt1, ir1); end
    drive(0, 0, 0, 1'b1);
    #1;
    tests_run++; if (rdy1 !== 1'b0) begin failed++; $display("FAIL skid_ready_registered got=%0b exp=0", rdy1); end
    tick();
    tests_run++; if (vld1 !== 1'b1 || ir1 !== 32'd101 || pc1 !== 32'd4 || rdy1 !== 1'b1 || cnt1 !== 16'd3) begin
      failed++; $display("FAIL skid_release got v=%0b pc=%0d ir=%0d rdy=%0b cnt=%0d", vld1, pc1, ir1, rdy1, cnt1); end
    tick();
    tests_run++; if (vld1 !== 1'b0) begin failed++; $display("FAIL skid_no_dup got v=%0b ir=%0d", vld1, ir1); end
  endtask

  task automatic test_flush();
    do_reset();
    drive(1, 32'd0, 32'd100, 1'b1);
    tick();
    drive(1, 32'd4, 32'd101, 1'b0);
    tick();
    drive(1, 32'd8, 32'd102, 1'b0);
    flush = 1;
    tick();
    flush = 0;
    drive(0, 0, 0, 1'b1);
    #1;
    tests_run++; if (vld1 !== 1'b0 || ir1 !== NOPW || pc1 !== 32'd0 || rdy1 !== 1'b1) begin
      failed++; $display("FAIL flush_out got v=%0b pc=%0d ir=%0h rdy=%0b", vld1, pc1, ir1, rdy1); end
    tests_run++; if (cnt1 !== 16'd2) begin failed++; $display("FAIL flush_cnt got=%0d exp=2", cnt1); end
    for (int i = 0; i < 3; i++) begin
      tick();
      tests_run++; if (vld1 !== 1'b0) begin failed++; $display("FAIL flush_squash%0d got v=%0b ir=%0d", i, vld1, ir1); end
    end
    drive(1, 32'd20, 32'd200, 1'b1);
    flush = 1;
    tick();
    flush = 0;
    drive(1, 32'd24, 32'd201, 1'b1);
    tick();
    tests_run++; if (vld1 !== 1'b1 || ir1 !== 32'd201) begin failed++; $display("FAIL flush_then_accept got v=%0b ir=%0d exp 201", vld1, ir1); end
  endtask

  task automatic test_noskid();
    do_reset();
    drive(1, 32'd40, 32'd300, 1'b1);
    tick();
    drive(1, 32'd44, 32'd301, 1'b0);
    #1;
    tests_run++; if (rdy0 !== 1'b0) begin failed++; $display("FAIL noskid_stall_ready got=%0b exp=0", rdy0); end
    tick();
    tests_run++; if (ir0 !== 32'd300 || pc0 !== 32'd40) begin failed++; $display("FAIL noskid_hold got pc=%0d ir=%0d", pc0, ir0); end
    out_ready = 1;
    #1;
    tests_run++; if (rdy0 !== 1'b1) begin failed++; $display("FAIL noskid_comb_ready got=%0b exp=1", rdy0); end
    tick();
    drive(0, 0, 0, 1'b1);
    #1;
    tests_run++; if (vld0 !== 1'b1 || ir0 !== 32'd301 || pc0 !== 32'd44) begin
      failed++; $display("FAIL noskid_swap got v=%0b pc=%0d ir=%0d", vld0, pc0, ir0); end
    tick();
    tests_run++; if (vld0 !== 1'b0 || ir0 !== NOPW) begin failed++; $display("FAIL noskid_drain got v=%0b ir=%0h", vld0, ir0); end
  endtask

  task automatic test_saturation();
    do_reset();
    drive(1, 32'd0, 32'd400, 1'b1);
    tick();
    drive(0, 0, 0, 1'b0);
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (i == 14) begin
        tests_run++; if (cntc !== 4'd14) begin failed++; $display("FAIL sat_pre got=%0d exp=14", cntc); end
      end
      if (i == 15) begin
        tests_run++; if (cntc !== 4'd15) begin failed++; $display("FAIL sat_reach got=%0d exp=15", cntc); end
      end
    end
    tests_run++; if (cntc !== 4'd15) begin failed++; $display("FAIL sat_hold got=%0d exp=15", cntc); end
    tests_run++; if (cnt1 !== 16'd20) begin failed++; $display("FAIL cnt16_run got=%0d exp=20", cnt1); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall_skid();
    test_flush();
    test_noskid();
    test_saturation();
    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end
endmodule
